// File: rtl/aes128_byte_serial_core.sv
// AES-128 encrypt/decrypt core, one round per clock, with byte-serial key/data load and unload.
// FIPS byte 0 of a block lives in [127:120]; dout is the least significant byte of the data register.
module aes128_byte_serial_core (
   input  logic       clk,
   input  logic       rst,
   input  logic       staenc,
   input  logic       stadec,
   input  logic       load_shift,
   input  logic       loadkey,
   input  logic [7:0] din,
   output logic [7:0] dout
);

   typedef enum logic [1:0] {S_IDLE, S_KEXP, S_ENC, S_DEC} fsm_t;

   fsm_t         fsm, fsm_next;
   logic [127:0] data_reg;
   logic [127:0] key_reg;
   logic [127:0] last_key;
   logic [127:0] rkey;
   logic [3:0]   round_cnt;
   logic         key_ready;
   logic         key_pend;

   logic         busy, last_round;
   logic         start_enc, start_dec, kexp_start, key_shift, data_shift;
   logic [127:0] rk_fwd, rk_inv;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h01;
      p = a;
      for (int i = 1; i < 8; i++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] i;
      i = ginv(a);
      return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      logic [7:0] y;
      y = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
      return ginv(y);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] n);
      case (n)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [31:0] sub_rot(input logic [31:0] w, input logic [7:0] rc);
      return {sbox(w[23:16]) ^ rc, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
   endfunction

   function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] n0, n1, n2, n3;
      n0 = k[127:96] ^ sub_rot(k[31:0], rc);
      n1 = k[95:64] ^ n0;
      n2 = k[63:32] ^ n1;
      n3 = k[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   // Undo one expansion step: w[i-4] = w[i] ^ f(w[i-1]).
   function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] n0, n1, n2, n3;
      n3 = k[31:0] ^ k[63:32];
      n2 = k[63:32] ^ k[95:64];
      n1 = k[95:64] ^ k[127:96];
      n0 = k[127:96] ^ sub_rot(n3, rc);
      return {n0, n1, n2, n3};
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] c);
      logic [7:0] s0, s1, s2, s3;
      {s0, s1, s2, s3} = c;
      return {xt(s0) ^ xt(s1) ^ s1 ^ s2 ^ s3,
              s0 ^ xt(s1) ^ xt(s2) ^ s2 ^ s3,
              s0 ^ s1 ^ xt(s2) ^ xt(s3) ^ s3,
              xt(s0) ^ s0 ^ s1 ^ s2 ^ xt(s3)};
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] s0, s1, s2, s3;
      {s0, s1, s2, s3} = c;
      return {gmul(s0, 8'h0e) ^ gmul(s1, 8'h0b) ^ gmul(s2, 8'h0d) ^ gmul(s3, 8'h09),
              gmul(s0, 8'h09) ^ gmul(s1, 8'h0e) ^ gmul(s2, 8'h0b) ^ gmul(s3, 8'h0d),
              gmul(s0, 8'h0d) ^ gmul(s1, 8'h09) ^ gmul(s2, 8'h0e) ^ gmul(s3, 8'h0b),
              gmul(s0, 8'h0b) ^ gmul(s1, 8'h0d) ^ gmul(s2, 8'h09) ^ gmul(s3, 8'h0e)};
   endfunction

   function automatic logic [127:0] enc_round(input logic [127:0] st, input logic [127:0] k,
                                              input logic last);
      logic [127:0] sh, mx;
      for (int cl = 0; cl < 4; cl++)
         for (int rw = 0; rw < 4; rw++)
            sh[127 - 8*(rw + 4*cl) -: 8] = sbox(st[127 - 8*(rw + 4*((cl + rw) % 4)) -: 8]);
      mx = sh;
      if (!last)
         for (int cl = 0; cl < 4; cl++)
            mx[127 - 32*cl -: 32] = mix_col(sh[127 - 32*cl -: 32]);
      return mx ^ k;
   endfunction

   function automatic logic [127:0] dec_round(input logic [127:0] st, input logic [127:0] k,
                                              input logic last);
      logic [127:0] sh, mx;
      for (int cl = 0; cl < 4; cl++)
         for (int rw = 0; rw < 4; rw++)
            sh[127 - 8*(rw + 4*cl) -: 8] = inv_sbox(st[127 - 8*(rw + 4*((cl - rw + 4) % 4)) -: 8]);
      sh = sh ^ k;
      mx = sh;
      if (!last)
         for (int cl = 0; cl < 4; cl++)
            mx[127 - 32*cl -: 32] = inv_mix_col(sh[127 - 32*cl -: 32]);
      return mx;
   endfunction

   assign dout       = data_reg[7:0];
   assign busy       = (fsm == S_ENC) || (fsm == S_DEC);
   assign last_round = (round_cnt == 4'd10);
   assign start_enc  = !busy && key_ready && staenc;
   assign start_dec  = !busy && key_ready && !staenc && stadec;
   assign key_shift  = !busy && !start_enc && !start_dec && loadkey;
   assign data_shift = !busy && !start_enc && !start_dec && !loadkey && load_shift;
   assign kexp_start = (fsm == S_IDLE) && key_pend && !loadkey;
   assign rk_fwd     = key_fwd(rkey, rcon(round_cnt));
   assign rk_inv     = key_inv(rkey, rcon(4'd11 - round_cnt));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) fsm <= S_IDLE;
      else      fsm <= fsm_next;
   end

   always_comb begin
      fsm_next = fsm;
      case (fsm)
         S_IDLE: begin
            if (start_enc)       fsm_next = S_ENC;
            else if (start_dec)  fsm_next = S_DEC;
            else if (kexp_start) fsm_next = S_KEXP;
         end
         S_KEXP:  if (loadkey || last_round) fsm_next = S_IDLE;
         default: if (last_round) fsm_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_reg  <= '0;
         key_reg   <= '0;
         last_key  <= '0;
         rkey      <= '0;
         round_cnt <= '0;
         key_ready <= 1'b0;
         key_pend  <= 1'b0;
      end else begin
         key_pend <= key_shift;
         if (key_shift) begin
            key_reg   <= {din, key_reg[127:8]};
            key_ready <= 1'b0;
         end
         if (data_shift) data_reg <= {din, data_reg[127:8]};

         if (start_enc) begin
            data_reg  <= data_reg ^ key_reg;
            rkey      <= key_reg;
            round_cnt <= 4'd1;
         end else if (start_dec) begin
            data_reg  <= data_reg ^ last_key;
            rkey      <= last_key;
            round_cnt <= 4'd1;
         end else if (kexp_start) begin
            rkey      <= key_fwd(key_reg, rcon(4'd1));
            round_cnt <= 4'd2;
         end

         case (fsm)
            S_KEXP: begin
               if (loadkey) begin
                  round_cnt <= '0;
               end else begin
                  rkey <= rk_fwd;
                  if (last_round) begin
                     last_key  <= rk_fwd;
                     key_ready <= 1'b1;
                     round_cnt <= '0;
                  end else begin
                     round_cnt <= round_cnt + 4'd1;
                  end
               end
            end
            S_ENC: begin
               rkey      <= rk_fwd;
               data_reg  <= enc_round(data_reg, rk_fwd, last_round);
               round_cnt <= last_round ? 4'd0 : round_cnt + 4'd1;
            end
            S_DEC: begin
               rkey      <= rk_inv;
               data_reg  <= dec_round(data_reg, rk_inv, last_round);
               round_cnt <= last_round ? 4'd0 : round_cnt + 4'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes128_byte_serial_core.sv
// Bench for aes128_byte_serial_core: FIPS-197 vectors plus randomized blocks against a table-driven AES model.
module tb_aes128_byte_serial_core;

   logic       clk;
   logic       rst;
   logic       staenc;
   logic       stadec;
   logic       load_shift;
   logic       loadkey;
   logic [7:0] din;
   logic [7:0] dout;

   int errs;
   int checks;

   logic [7:0]   sb [256];
   logic [7:0]   isb[256];
   logic [127:0] ks [11];

   localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   aes128_byte_serial_core dut (
      .clk        (clk),
      .rst        (rst),
      .staenc     (staenc),
      .stadec     (stadec),
      .load_shift (load_shift),
      .loadkey    (loadkey),
      .din        (din),
      .dout       (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc, aa, bb;
      acc = 8'h00;
      aa  = a;
      bb  = b;
      while (bb != 8'h00) begin
         if (bb[0]) acc = acc ^ aa;
         aa = xtime(aa);
         bb = bb >> 1;
      end
      return acc;
   endfunction

   // Walk the generator 3 and its inverse to fill the S-box table.
   function automatic void build_tables();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      sb[0] = 8'h63;
      for (int n = 0; n < 255; n++) begin
         p = p ^ xtime(p);
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sb[p] = x ^ 8'h63;
      end
      for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
   endfunction

   function automatic void expand(input logic [127:0] k);
      logic [31:0] w[44];
      logic [31:0] t;
      logic [7:0]  rc;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {sb[t[23:16]] ^ rc, sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]};
            rc = xtime(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   function automatic logic [127:0] model_enc(input logic [127:0] key, input logic [127:0] pt);
      logic [7:0]   s[4][4];
      logic [7:0]   t[4][4];
      logic [127:0] v;
      expand(key);
      v = pt ^ ks[0];
      for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) s[r][c] = v[127 - 8*(4*c + r) -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) t[r][c] = sb[s[r][(c + r) % 4]];
         for (int c = 0; c < 4; c++) begin
            if (rnd < 10) begin
               s[0][c] = gm(t[0][c], 8'h02) ^ gm(t[1][c], 8'h03) ^ t[2][c] ^ t[3][c];
               s[1][c] = t[0][c] ^ gm(t[1][c], 8'h02) ^ gm(t[2][c], 8'h03) ^ t[3][c];
               s[2][c] = t[0][c] ^ t[1][c] ^ gm(t[2][c], 8'h02) ^ gm(t[3][c], 8'h03);
               s[3][c] = gm(t[0][c], 8'h03) ^ t[1][c] ^ t[2][c] ^ gm(t[3][c], 8'h02);
            end else begin
               for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
            end
         end
         for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++)
            s[r][c] = s[r][c] ^ ks[rnd][127 - 8*(4*c + r) -: 8];
      end
      for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) v[127 - 8*(4*c + r) -: 8] = s[r][c];
      return v;
   endfunction

   function automatic logic [127:0] model_dec(input logic [127:0] key, input logic [127:0] ct);
      logic [7:0]   s[4][4];
      logic [7:0]   t[4][4];
      logic [127:0] v;
      expand(key);
      v = ct ^ ks[10];
      for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) s[r][c] = v[127 - 8*(4*c + r) -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++)
            t[r][c] = isb[s[r][(c - r + 4) % 4]] ^ ks[10 - rnd][127 - 8*(4*c + r) -: 8];
         for (int c = 0; c < 4; c++) begin
            if (rnd < 10) begin
               s[0][c] = gm(t[0][c], 8'h0e) ^ gm(t[1][c], 8'h0b) ^ gm(t[2][c], 8'h0d) ^ gm(t[3][c], 8'h09);
               s[1][c] = gm(t[0][c], 8'h09) ^ gm(t[1][c], 8'h0e) ^ gm(t[2][c], 8'h0b) ^ gm(t[3][c], 8'h0d);
               s[2][c] = gm(t[0][c], 8'h0d) ^ gm(t[1][c], 8'h09) ^ gm(t[2][c], 8'h0e) ^ gm(t[3][c], 8'h0b);
               s[3][c] = gm(t[0][c], 8'h0b) ^ gm(t[1][c], 8'h0d) ^ gm(t[2][c], 8'h09) ^ gm(t[3][c], 8'h0e);
            end else begin
               for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
            end
         end
      end
      for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) v[127 - 8*(4*c + r) -: 8] = s[r][c];
      return v;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- stimulus primitives ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic load_key(input logic [127:0] k);
      loadkey = 1'b1;
      for (int i = 0; i < 16; i++) begin
         din = k[8*i +: 8];
         step(1);
      end
      loadkey = 1'b0;
      din     = 8'h00;
      step(12);
   endtask

   task automatic load_block(input logic [127:0] b);
      load_shift = 1'b1;
      for (int i = 0; i < 16; i++) begin
         din = b[8*i +: 8];
         step(1);
      end
      load_shift = 1'b0;
      din        = 8'h00;
   endtask

   // Strobe plus ten round edges: the result is in the register on return.
   task automatic run_op(input logic enc);
      staenc = enc;
      stadec = !enc;
      step(1);
      staenc = 1'b0;
      stadec = 1'b0;
      step(10);
   endtask

   task automatic unload(input logic [127:0] nxt, output logic [127:0] got);
      for (int i = 0; i < 16; i++) begin
         got[8*i +: 8] = dout;
         load_shift = 1'b1;
         din        = nxt[8*i +: 8];
         step(1);
      end
      load_shift = 1'b0;
      din        = 8'h00;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0;
      step(2);
      checks++;
      if (dout !== 8'h00) begin
         errs++;
         $display("FAIL reset_dout: got %h expected 00", dout);
      end
      rst = 1'b1;
      step(1);
   endtask

   task automatic test_start_no_key();
      logic [127:0] b, got;
      run_op(1'b1);
      step(2);
      checks++;
      if (dout !== 8'h00) begin
         errs++;
         $display("FAIL nokey_zero_dout: got %h expected 00", dout);
      end
      b = rand128();
      load_block(b);
      run_op(1'b1);
      run_op(1'b0);
      step(2);
      unload(128'h0, got);
      checks++;
      if (got !== b) begin
         errs++;
         $display("FAIL nokey_block_unchanged: got %h expected %h", got, b);
      end
   endtask

   task automatic test_encrypt_fips();
      logic [127:0] got;
      load_key(FK);
      load_block(FP);
      run_op(1'b1);
      checks++;
      if (dout !== 8'h5a) begin
         errs++;
         $display("FAIL enc_latency_byte0: got %h expected 5a", dout);
      end
      step(2);
      unload(FC, got);
      checks++;
      if (got !== FC) begin
         errs++;
         $display("FAIL enc_fips: got %h expected %h", got, FC);
      end
      checks++;
      if (got !== model_enc(FK, FP)) begin
         errs++;
         $display("FAIL enc_fips_model: got %h expected %h", got, model_enc(FK, FP));
      end
   endtask

   task automatic test_decrypt_fips();
      logic [127:0] got;
      // Ciphertext was shifted in while the previous result was unloaded.
      run_op(1'b0);
      checks++;
      if (dout !== 8'hff) begin
         errs++;
         $display("FAIL dec_latency_byte0: got %h expected ff", dout);
      end
      step(2);
      unload(128'h0, got);
      checks++;
      if (got !== FP) begin
         errs++;
         $display("FAIL dec_fips: got %h expected %h", got, FP);
      end
   endtask

   task automatic test_random();
      logic [127:0] k, p, c, exp_v, got;
      for (int n = 0; n < 6; n++) begin
         k = rand128();
         p = rand128();
         c = rand128();
         load_key(k);
         load_block(p);
         run_op(1'b1);
         step(2);
         exp_v = model_enc(k, p);
         unload(exp_v, got);
         checks++;
         if (got !== exp_v) begin
            errs++;
            $display("FAIL rand_enc[%0d]: got %h expected %h", n, got, exp_v);
         end
         run_op(1'b0);
         step(2);
         unload(c, got);
         checks++;
         if (got !== p) begin
            errs++;
            $display("FAIL rand_roundtrip[%0d]: got %h expected %h", n, got, p);
         end
         run_op(1'b0);
         exp_v = model_dec(k, c);
         unload(128'h0, got);
         checks++;
         if (got !== exp_v) begin
            errs++;
            $display("FAIL rand_dec[%0d]: got %h expected %h", n, got, exp_v);
         end
      end
   endtask

   task automatic test_busy_lockout();
      logic [127:0] got;
      load_key(FK);
      load_block(FP);
      staenc = 1'b1;
      step(1);
      for (int e = 1; e <= 10; e++) begin
         load_shift = 1'($urandom_range(1, 0));
         loadkey    = 1'($urandom_range(1, 0));
         staenc     = 1'($urandom_range(1, 0));
         stadec     = 1'($urandom_range(1, 0));
         din        = 8'($urandom);
         step(1);
      end
      load_shift = 1'b0;
      loadkey    = 1'b0;
      staenc     = 1'b0;
      stadec     = 1'b0;
      din        = 8'h00;
      checks++;
      if (dout !== 8'h5a) begin
         errs++;
         $display("FAIL busy_byte0: got %h expected 5a", dout);
      end
      step(2);
      unload(FP, got);
      checks++;
      if (got !== FC) begin
         errs++;
         $display("FAIL busy_result: got %h expected %h", got, FC);
      end
      run_op(1'b1);
      unload(128'h0, got);
      checks++;
      if (got !== FC) begin
         errs++;
         $display("FAIL busy_key_intact: got %h expected %h", got, FC);
      end
   endtask

   task automatic test_priority();
      logic [127:0] k2, b, exp_v, got;
      k2 = rand128();
      b  = rand128();
      load_block(b);
      loadkey    = 1'b1;
      load_shift = 1'b1;
      for (int i = 0; i < 16; i++) begin
         din = k2[8*i +: 8];
         step(1);
         checks++;
         if (dout !== b[7:0]) begin
            errs++;
            $display("FAIL priority_dout[%0d]: got %h expected %h", i, dout, b[7:0]);
         end
      end
      loadkey    = 1'b0;
      load_shift = 1'b0;
      din        = 8'h00;
      step(12);
      run_op(1'b1);
      exp_v = model_enc(k2, b);
      unload(128'h0, got);
      checks++;
      if (got !== exp_v) begin
         errs++;
         $display("FAIL priority_newkey: got %h expected %h", got, exp_v);
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] k, a, exp_v, got;
      k = rand128();
      a = rand128();
      load_key(k);
      load_block(a);
      run_op(1'b1);
      run_op(1'b1);
      exp_v = model_enc(k, model_enc(k, a));
      unload(exp_v, got);
      checks++;
      if (got !== exp_v) begin
         errs++;
         $display("FAIL b2b_enc: got %h expected %h", got, exp_v);
      end
      run_op(1'b0);
      run_op(1'b0);
      unload(128'h0, got);
      checks++;
      if (got !== a) begin
         errs++;
         $display("FAIL b2b_dec: got %h expected %h", got, a);
      end
   endtask

   task automatic test_reset_mid();
      logic [127:0] got;
      load_key(FK);
      load_block(FP);
      staenc = 1'b1;
      step(1);
      staenc = 1'b0;
      step(4);
      rst = 1'b0;
      #1;
      checks++;
      if (dout !== 8'h00) begin
         errs++;
         $display("FAIL midreset_dout: got %h expected 00", dout);
      end
      step(2);
      rst = 1'b1;
      run_op(1'b1);
      step(2);
      unload(FP, got);
      checks++;
      if (got !== 128'h0) begin
         errs++;
         $display("FAIL midreset_cleared: got %h expected 0", got);
      end
      run_op(1'b1);
      step(2);
      unload(128'h0, got);
      checks++;
      if (got !== FP) begin
         errs++;
         $display("FAIL midreset_keyless: got %h expected %h", got, FP);
      end
      load_key(FK);
      load_block(FP);
      run_op(1'b1);
      unload(128'h0, got);
      checks++;
      if (got !== FC) begin
         errs++;
         $display("FAIL midreset_reload: got %h expected %h", got, FC);
      end
   endtask

   initial begin
      errs       = 0;
      checks     = 0;
      rst        = 1'b0;
      staenc     = 1'b0;
      stadec     = 1'b0;
      load_shift = 1'b0;
      loadkey    = 1'b0;
      din        = 8'h00;
      build_tables();

      test_reset();
      test_start_no_key();
      test_encrypt_fips();
      test_decrypt_fips();
      test_random();
      test_busy_lockout();
      test_priority();
      test_back_to_back();
      test_reset_mid();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
